// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole engine: game states, command bytes
// and the mole-placement LFSR constants.
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam logic [7:0] CMD_START  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_PAUSE  = 8'h50;  // 'P'
  localparam logic [7:0] CMD_RETURN = 8'h52;  // 'R'
  localparam logic [7:0] CMD_HOLE0  = 8'h41;  // 'A'

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR used as the mole placement source.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  logic [15:0] lfsr_r;

  // LFSR state register, advances every cycle regardless of game state
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/mole_game_engine.sv
// Whack-a-mole game engine: command decode, game timer, mole spawn/lifetime
// and score bookkeeping. Every output is a register.
module mole_game_engine
  import mole_pkg::*;
#(
  parameter int CLK_FRE     = 50,
  parameter int HOLES       = 16,
  parameter int GAME_SEC    = 60,
  parameter int MOLE_FRAMES = 64,
  parameter int SCORE_W     = 8,
  parameter int TICK_CYCLES = CLK_FRE * 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vs_in,
  input  logic [7:0]               rx_data,
  input  logic                     rx_data_en,
  input  logic [1:0]               level,
  output logic [1:0]               state,
  output logic [$clog2(HOLES)-1:0] mole_pos,
  output logic                     mole_valid,
  output logic [SCORE_W-1:0]       mole_score,
  output logic [SCORE_W-1:0]       miss_count,
  output logic [11:0]              left_time,
  output logic                     hit_pulse
);

  localparam int                 POS_W     = $clog2(HOLES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [11:0]        GAME_TIME = 12'(GAME_SEC);
  localparam logic [31:0]        TICK_LAST = 32'(TICK_CYCLES - 1);
  localparam logic [7:0]         HOLE_LAST = 8'(CMD_HOLE0 + HOLES - 1);

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                 input logic [1:0]         inc);
    logic [SCORE_W+1:0] sum;
    sum = {2'b00, base} + {{SCORE_W{1'b0}}, inc};
    if (sum > {2'b00, SCORE_MAX}) begin
      return SCORE_MAX;
    end else begin
      return sum[SCORE_W-1:0];
    end
  endfunction

  game_state_t        state_r, state_s;
  logic               mole_valid_r, mole_valid_s;
  logic [POS_W-1:0]   mole_pos_r, mole_pos_s;
  logic [SCORE_W-1:0] score_r, score_s;
  logic [SCORE_W-1:0] miss_r, miss_s;
  logic [11:0]        left_time_r, left_time_s;
  logic               hit_pulse_r, hit_pulse_s;
  logic [31:0]        tick_cnt_r, tick_cnt_s;
  logic [7:0]         life_cnt_r, life_cnt_s;
  logic [1:0]         level_r, level_s;
  logic               vs_d_r;
  logic               expire_s;

  logic [15:0]      lfsr_s;
  logic             lfsr_unused_s;
  logic             frame_s;
  logic             cmd_start_s, cmd_pause_s, cmd_return_s, cmd_hit_s, hit_ok_s;
  logic             tick_s, final_tick_s;
  logic [7:0]       life_last_s;
  logic [POS_W-1:0] spawn_pos_s;

  mole_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_s)
  );

  assign lfsr_unused_s = ^lfsr_s;
  assign frame_s       = vs_in & ~vs_d_r;
  assign cmd_start_s   = rx_data_en & (rx_data == CMD_START);
  assign cmd_pause_s   = rx_data_en & (rx_data == CMD_PAUSE);
  assign cmd_return_s  = rx_data_en & (rx_data == CMD_RETURN);
  // With 16 holes 'P' would also name hole 15; the pause meaning wins
  assign cmd_hit_s     = rx_data_en & (rx_data >= CMD_HOLE0) & (rx_data <= HOLE_LAST)
                         & (rx_data != CMD_PAUSE);
  assign hit_ok_s      = cmd_hit_s & mole_valid_r
                         & (rx_data == (CMD_HOLE0 + 8'(mole_pos_r)));
  assign tick_s        = (state_r == ST_RUN) & (tick_cnt_r == TICK_LAST);
  assign final_tick_s  = tick_s & (left_time_r == 12'd1);
  assign life_last_s   = (8'(MOLE_FRAMES) >> level_r) - 8'd1;
  assign spawn_pos_s   = (lfsr_s[POS_W-1:0] == mole_pos_r) ? (mole_pos_r + POS_W'(1))
                                                          : lfsr_s[POS_W-1:0];

  // Next-state logic for the game FSM and all datapath registers
  always_comb begin
    state_s      = state_r;
    mole_valid_s = mole_valid_r;
    mole_pos_s   = mole_pos_r;
    score_s      = score_r;
    miss_s       = miss_r;
    left_time_s  = left_time_r;
    hit_pulse_s  = 1'b0;
    tick_cnt_s   = tick_cnt_r;
    life_cnt_s   = life_cnt_r;
    level_s      = level_r;
    expire_s     = 1'b0;

    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (cmd_start_s) begin
          state_s      = ST_RUN;
          left_time_s  = GAME_TIME;
          score_s      = {SCORE_W{1'b0}};
          miss_s       = {SCORE_W{1'b0}};
          tick_cnt_s   = 32'd0;
          life_cnt_s   = 8'd0;
          level_s      = level;
          mole_valid_s = 1'b0;
        end else if (cmd_return_s) begin
          state_s      = ST_IDLE;
          mole_valid_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      ST_RUN: begin
        tick_cnt_s = tick_s ? 32'd0 : (tick_cnt_r + 32'd1);

        if (frame_s && !mole_valid_r) begin
          mole_valid_s = 1'b1;
          mole_pos_s   = spawn_pos_s;
          life_cnt_s   = 8'd0;
        end else if (frame_s && (life_cnt_r == life_last_s)) begin
          mole_valid_s = 1'b0;
          expire_s     = 1'b1;
        end else if (frame_s) begin
          life_cnt_s = life_cnt_r + 8'd1;
        end else begin
          life_cnt_s = life_cnt_r;
        end

        // A correct hit cancels a same-cycle expiry miss
        if (hit_ok_s) begin
          score_s      = sat_add(score_r, 2'd1);
          hit_pulse_s  = 1'b1;
          mole_valid_s = 1'b0;
          miss_s       = miss_r;
        end else begin
          miss_s = sat_add(miss_r, {1'b0, expire_s} + {1'b0, cmd_hit_s});
        end

        if (final_tick_s) begin
          left_time_s  = 12'd0;
          mole_valid_s = 1'b0;
        end else if (tick_s) begin
          left_time_s = left_time_r - 12'd1;
        end else begin
          left_time_s = left_time_r;
        end

        if (cmd_return_s) begin
          state_s      = ST_IDLE;
          mole_valid_s = 1'b0;
        end else if (final_tick_s) begin
          state_s = ST_OVER;
        end else if (cmd_pause_s) begin
          state_s = ST_PAUSE;
        end else begin
          state_s = ST_RUN;
        end
      end

      ST_PAUSE: begin
        if (cmd_return_s) begin
          state_s      = ST_IDLE;
          mole_valid_s = 1'b0;
        end else if (cmd_pause_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSE;
        end
      end

      default: begin
        state_s      = ST_IDLE;
        mole_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      mole_valid_r <= 1'b0;
      mole_pos_r   <= {POS_W{1'b0}};
      score_r      <= {SCORE_W{1'b0}};
      miss_r       <= {SCORE_W{1'b0}};
      left_time_r  <= GAME_TIME;
      hit_pulse_r  <= 1'b0;
      tick_cnt_r   <= 32'd0;
      life_cnt_r   <= 8'd0;
      level_r      <= 2'd0;
      vs_d_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      mole_valid_r <= mole_valid_s;
      mole_pos_r   <= mole_pos_s;
      score_r      <= score_s;
      miss_r       <= miss_s;
      left_time_r  <= left_time_s;
      hit_pulse_r  <= hit_pulse_s;
      tick_cnt_r   <= tick_cnt_s;
      life_cnt_r   <= life_cnt_s;
      level_r      <= level_s;
      vs_d_r       <= vs_in;
    end
  end

  assign state      = state_r;
  assign mole_pos   = mole_pos_r;
  assign mole_valid = mole_valid_r;
  assign mole_score = score_r;
  assign miss_count = miss_r;
  assign left_time  = left_time_r;
  assign hit_pulse  = hit_pulse_r;

endmodule

// File: tb/tb_mole_game_engine.sv
// Directed self-checking bench for mole_game_engine: a vector table for the
// command/state behaviour plus hand-written multi-cycle sequences.
module tb_mole_game_engine;

  localparam int TICK = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs_in;
  logic [7:0]  rx_data;
  logic        rx_data_en;
  logic [1:0]  level;
  logic [1:0]  state;
  logic [2:0]  mole_pos;
  logic        mole_valid;
  logic [1:0]  mole_score;
  logic [1:0]  miss_count;
  logic [11:0] left_time;
  logic        hit_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_lfsr;
  logic [2:0]  exp_pos;

  mole_game_engine #(
    .CLK_FRE     (1),
    .HOLES       (8),
    .GAME_SEC    (2),
    .MOLE_FRAMES (64),
    .SCORE_W     (2),
    .TICK_CYCLES (TICK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vs_in      (vs_in),
    .rx_data    (rx_data),
    .rx_data_en (rx_data_en),
    .level      (level),
    .state      (state),
    .mole_pos   (mole_pos),
    .mole_valid (mole_valid),
    .mole_score (mole_score),
    .miss_count (miss_count),
    .left_time  (left_time),
    .hit_pulse  (hit_pulse)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois form, seed ACE1
  always @(posedge clk) begin
    if (rst) model_lfsr <= 16'hACE1;
    else     model_lfsr <= {1'b0, model_lfsr[15:1]} ^ (model_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct {
    logic        vs;
    logic [7:0]  data;
    logic        en;
    logic [1:0]  lvl;
    logic        chk_pos;
    logic [1:0]  e_state;
    logic        e_valid;
    logic [1:0]  e_score;
    logic [1:0]  e_miss;
    logic [11:0] e_left;
    logic        e_hit;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs at a falling edge, return at the next falling edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic e);
    vs_in      = v;
    rx_data    = d;
    rx_data_en = e;
    @(negedge clk);
    rx_data_en = 1'b0;
  endtask

  // Must be called just before the cycle carrying the spawning frame edge
  task automatic predict_spawn();
    logic [2:0] c;
    c = model_lfsr[2:0];
    if (c == exp_pos) c = c + 3'd1;
    exp_pos = c;
  endtask

  function automatic logic [7:0] hole_cmd(input logic [2:0] p);
    return 8'h41 + {5'b00000, p};
  endfunction

  initial begin
    //          vs  data   en lvl pos  st  v  sc mi left hit
    vecs[0]  = '{0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 2, 0};
    vecs[1]  = '{0, 8'h50, 1, 0, 0,   0, 0, 0, 0, 2, 0};  // P in IDLE
    vecs[2]  = '{0, 8'h41, 1, 0, 0,   0, 0, 0, 0, 2, 0};  // hit in IDLE
    vecs[3]  = '{0, 8'h78, 1, 0, 0,   0, 0, 0, 0, 2, 0};  // 'x' ignored
    vecs[4]  = '{0, 8'h53, 1, 0, 0,   1, 0, 0, 0, 2, 0};  // S
    vecs[5]  = '{0, 8'h53, 1, 0, 0,   1, 0, 0, 0, 2, 0};  // S in RUN
    vecs[6]  = '{0, 8'h42, 1, 0, 0,   1, 0, 0, 1, 2, 0};  // hit, no mole
    vecs[7]  = '{0, 8'h50, 1, 0, 0,   2, 0, 0, 1, 2, 0};  // pause
    vecs[8]  = '{0, 8'h43, 1, 0, 0,   2, 0, 0, 1, 2, 0};  // hit in PAUSE
    vecs[9]  = '{1, 8'h00, 0, 0, 0,   2, 0, 0, 1, 2, 0};  // frame in PAUSE
    vecs[10] = '{0, 8'h50, 1, 0, 0,   1, 0, 0, 1, 2, 0};  // resume
    vecs[11] = '{1, 8'h00, 0, 0, 1,   1, 1, 0, 1, 2, 0};  // spawn
    vecs[12] = '{0, 8'h00, 0, 0, 0,   1, 1, 0, 1, 2, 0};
    vecs[13] = '{0, 8'h52, 1, 0, 0,   0, 0, 0, 1, 2, 0};  // R

    rst = 1'b1; vs_in = 1'b0; rx_data = 8'h00; rx_data_en = 1'b0; level = 2'd0;
    exp_pos = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      level = vecs[i].lvl;
      if (vecs[i].chk_pos) predict_spawn();
      cyc(vecs[i].vs, vecs[i].data, vecs[i].en);
      chk($sformatf("vec%0d state", i), state, vecs[i].e_state);
      chk($sformatf("vec%0d valid", i), mole_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d score", i), mole_score, vecs[i].e_score);
      chk($sformatf("vec%0d miss", i), miss_count, vecs[i].e_miss);
      chk($sformatf("vec%0d left", i), left_time, vecs[i].e_left);
      chk($sformatf("vec%0d hit", i), hit_pulse, vecs[i].e_hit);
      if (vecs[i].chk_pos) chk($sformatf("vec%0d pos", i), mole_pos, exp_pos);
    end

    // Start, spawn, correct hit, wrong-hole misses
    cyc(0, 8'h53, 1);
    chk("start state", state, 1);
    chk("start left", left_time, 2);
    predict_spawn();
    cyc(1, 8'h00, 0);
    chk("first spawn valid", mole_valid, 1);
    chk("first spawn pos", mole_pos, exp_pos);
    cyc(0, 8'h00, 0);
    cyc(0, hole_cmd(exp_pos), 1);
    chk("hit pulse", hit_pulse, 1);
    chk("hit score", mole_score, 1);
    chk("hit clears mole", mole_valid, 0);
    cyc(0, 8'h00, 0);
    chk("hit pulse one cycle", hit_pulse, 0);
    cyc(0, hole_cmd(exp_pos + 3'd1), 1);
    chk("miss no mole", miss_count, 1);
    predict_spawn();
    cyc(1, 8'h00, 0);
    chk("respawn pos", mole_pos, exp_pos);
    cyc(0, 8'h00, 0);
    cyc(0, hole_cmd(exp_pos + 3'd1), 1);
    chk("wrong hole miss", miss_count, 2);
    chk("wrong hole keeps mole", mole_valid, 1);
    chk("wrong hole score", mole_score, 1);

    // Level 2: 16-frame lifetime, then hit coincident with expiry, saturation
    cyc(0, 8'h52, 1);
    level = 2'd2;
    cyc(0, 8'h53, 1);
    level = 2'd0;
    predict_spawn();
    cyc(1, 8'h00, 0);
    cyc(0, 8'h00, 0);
    for (int f = 1; f <= 15; f++) begin
      cyc(1, 8'h00, 0);
      cyc(0, 8'h00, 0);
    end
    chk("alive after 15 frames", mole_valid, 1);
    chk("no miss before expiry", miss_count, 0);
    cyc(1, 8'h00, 0);
    chk("expired at frame 16", mole_valid, 0);
    chk("expiry miss", miss_count, 1);
    cyc(0, 8'h00, 0);
    predict_spawn();
    cyc(1, 8'h00, 0);
    cyc(0, 8'h00, 0);
    for (int f = 1; f <= 15; f++) begin
      cyc(1, 8'h00, 0);
      cyc(0, 8'h00, 0);
    end
    cyc(1, hole_cmd(exp_pos), 1);
    chk("hit+expiry score", mole_score, 1);
    chk("hit+expiry miss", miss_count, 1);
    chk("hit+expiry pulse", hit_pulse, 1);
    chk("hit+expiry valid", mole_valid, 0);
    cyc(0, 8'h00, 0);
    for (int h = 2; h <= 4; h++) begin
      predict_spawn();
      cyc(1, 8'h00, 0);
      cyc(0, 8'h00, 0);
      cyc(0, hole_cmd(exp_pos), 1);
      chk($sformatf("hit%0d pulse", h), hit_pulse, 1);
      chk($sformatf("hit%0d score", h), mole_score, (h > 3) ? 3 : h);
    end
    for (int m = 0; m < 4; m++) cyc(0, 8'h41, 1);
    chk("miss saturates", miss_count, 3);

    // Game timer with a 100-cycle pause and a hit on the final tick
    cyc(0, 8'h52, 1);
    cyc(0, 8'h53, 1);
    for (int n = 1; n <= 500; n++) begin
      logic       v;
      logic [7:0] d;
      logic       e;
      v = 1'b0; d = 8'h00; e = 1'b0;
      if (n == 51 || n == 151) begin d = 8'h50; e = 1'b1; end
      if (n == 490) begin predict_spawn(); v = 1'b1; end
      if (n == 500) begin d = hole_cmd(exp_pos); e = 1'b1; end
      cyc(v, d, e);
      if (n == 100) chk("paused", state, 2);
      if (n == 151) chk("resumed", state, 1);
      if (n == 299) chk("left before tick", left_time, 2);
      if (n == 300) chk("left after tick", left_time, 1);
      if (n == 490) chk("late spawn pos", mole_pos, exp_pos);
      if (n == 499) chk("still running", state, 1);
      if (n == 500) begin
        chk("over state", state, 3);
        chk("over left", left_time, 0);
        chk("final hit score", mole_score, 1);
        chk("final hit pulse", hit_pulse, 1);
        chk("over valid", mole_valid, 0);
        chk("over miss", miss_count, 0);
      end
    end
    cyc(0, 8'h42, 1);
    chk("hit in OVER ignored", miss_count, 0);
    chk("hit in OVER state", state, 3);
    cyc(0, 8'h53, 1);
    chk("restart state", state, 1);
    chk("restart left", left_time, 2);
    chk("restart score", mole_score, 0);

    // Reset mid-game together with a pause command
    predict_spawn();
    cyc(1, 8'h00, 0);
    cyc(0, 8'h00, 0);
    rst = 1'b1;
    cyc(0, 8'h50, 1);
    rst = 1'b0;
    exp_pos = 3'd0;
    chk("rst state", state, 0);
    chk("rst valid", mole_valid, 0);
    chk("rst pos", mole_pos, 0);
    chk("rst score", mole_score, 0);
    chk("rst miss", miss_count, 0);
    chk("rst left", left_time, 2);
    chk("rst hit", hit_pulse, 0);
    cyc(0, 8'h53, 1);
    predict_spawn();
    cyc(1, 8'h00, 0);
    chk("post-rst spawn pos", mole_pos, exp_pos);
    chk("post-rst spawn valid", mole_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_game_engine.md
MOLE_GAME_ENGINE -- requirements
Module: mole_game_engine

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, clk frequency in MHz used for the 1 s tick.
REQ-002 SHALL have parameter HOLES, default 16, hole count; legal values are 4, 8 or 16.
REQ-003 SHALL have parameter GAME_SEC, default 60, game length in seconds; range 1..4095.
REQ-004 SHALL have parameter MOLE_FRAMES, default 64, base mole lifetime in frames; range 8..255.
REQ-005 SHALL have parameter SCORE_W, default 8, width of the score and miss counters.
REQ-006 SHALL have port clk, input, 1 bit: single system clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port vs_in, input, 1 bit: video vsync, synchronous to clk; its rising edge is a frame event.
REQ-009 SHALL have port rx_data, input, 8 bits: ASCII command byte.
REQ-010 SHALL have port rx_data_en, input, 1 bit: one-cycle strobe qualifying rx_data, synchronous to clk.
REQ-011 SHALL have port level, input, 2 bits: difficulty; sampled only on start.
REQ-012 SHALL have port state, output, 2 bits: IDLE=0, RUN=1, PAUSE=2, OVER=3.
REQ-013 SHALL have port mole_pos, output, $clog2(HOLES) bits: current mole hole index.
REQ-014 SHALL have port mole_valid, output, 1 bit: a mole is currently shown.
REQ-015 SHALL have port mole_score, output, SCORE_W bits: hit count.
REQ-016 SHALL have port miss_count, output, SCORE_W bits: wrong-hole hits plus timed-out moles.
REQ-017 SHALL have port left_time, output, 12 bits: remaining seconds.
REQ-018 SHALL have port hit_pulse, output, 1 bit: one-cycle pulse on each successful hit.

Function
REQ-019 All outputs SHALL be registered; each response SHALL appear exactly one clk cycle after the triggering rx_data_en or vs_in edge.
REQ-020 Command decode: 'S' = start/restart; 'P' = pause toggle; 'R' = return to IDLE; 'A'..'A'+HOLES-1 = hit hole 0..HOLES-1; all other bytes are ignored.
REQ-021 'S' is accepted in IDLE and OVER and SHALL: go to RUN; load left_time=GAME_SEC; clear score, miss count and the tick counter; latch level; spawn a mole on the next frame event.
REQ-022 'P' SHALL move RUN to PAUSE and PAUSE to RUN; it is ignored in other states.
REQ-023 In PAUSE, the tick counter, left_time and mole lifetime counter SHALL hold, mole_valid SHALL hold, and hit commands SHALL be ignored.
REQ-024 'R' SHALL go to IDLE from any state; mole_valid=0; score and time SHALL hold for display.
REQ-025 The 1 s tick SHALL fire every CLK_FRE*1_000_000 cycles, counted only in RUN; on a tick left_time SHALL decrement.
REQ-026 When left_time goes 1 -> 0 the block SHALL enter OVER and set mole_valid=0; hit commands in OVER are ignored.
REQ-027 Spawn: on a frame event while in RUN with mole_valid=0, the block SHALL take the low $clog2(HOLES) bits of a 16-bit Galois LFSR (seed 16'hACE1, polynomial x^16+x^14+x^13+x^11+1); if that equals the previous mole_pos it SHALL use pos+1 modulo HOLES; then mole_valid=1.
REQ-028 The LFSR SHALL advance every clk cycle in all states.
REQ-029 Mole lifetime SHALL be MOLE_FRAMES >> latched level frames, counted on frame events in RUN.
REQ-030 On lifetime expiry the block SHALL set mole_valid=0 and increment miss_count; the next spawn occurs on the next frame event.
REQ-031 Hit: in RUN with mole_valid=1 and hole == mole_pos, the block SHALL increment mole_score, pulse hit_pulse, and set mole_valid=0.
REQ-032 A hit on a wrong hole, or any hit while mole_valid=0, SHALL increment miss_count.
REQ-033 mole_score and miss_count SHALL saturate at all-ones.
REQ-034 If a hit and a lifetime expiry occur in the same cycle, the hit SHALL win and miss_count SHALL be unchanged.
REQ-035 If the final tick and a hit occur in the same cycle, the hit SHALL be scored and the state SHALL then go to OVER.
REQ-036 A frame event and a command in the same cycle SHALL both be processed; the command takes priority for mole_valid.

Reset
REQ-037 rst SHALL force: state=IDLE, mole_valid=0, mole_pos=0, mole_score=0, miss_count=0, left_time=GAME_SEC, hit_pulse=0, LFSR=16'hACE1, all counters=0, vs edge register=0.
REQ-038 rst asserted mid-game SHALL take effect on the next clk edge, overriding any simultaneous command.

Structure
REQ-039 Package mole_pkg SHALL hold the state enum, the command character constants and the LFSR seed and taps.
REQ-040 The LFSR SHALL be a separate sub-module, mole_lfsr, with ports clk, rst and a 16-bit value output.

Verification
REQ-041 Reset, then 'S': state=1, left_time=60, mole_valid=1 one cycle after the first vs_in rising edge.
REQ-042 Send 'A'+mole_pos: hit_pulse high for 1 cycle, score 0->1, mole_valid=0; then send a wrong hole: miss_count 0->1.
REQ-043 level=2, no hits: mole_valid falls after exactly 16 frames and miss_count increments.
REQ-044 CLK_FRE=1, GAME_SEC=2: state=OVER after 2,000,000 RUN cycles; a 'P' of 1000 cycles extends this by exactly 1000 cycles.
REQ-045 Hit and expiry in the same cycle: score+1, miss unchanged; with SCORE_W=2, four hits leave score=3.
REQ-046 rst pulsed in RUN concurrent with 'P': all outputs match REQ-037 on the next cycle.
